unsigned_mul_approx_pipe: RTL and testbench
===========================================

UNSIGNED_MUL_APPROX_PIPE -- requirements
Module: unsigned_mul_approx_pipe

Interface
REQ-001 The block SHALL provide these parameters, one per line: name, default, meaning.
- W, 8, operand width; even, 4..32.
- APPROX_COLS, 4, number of low product columns (bits 0..APPROX_COLS-1) subject to approximation; 0..2W.
REQ-002 The block SHALL provide these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block accepts operands this cycle.
- x  in  W  multiplicand, unsigned.
- y  in  W  multiplier, unsigned.
- mode  in  2  0=exact, 1=OR-compress, 2=truncate, 3=reserved (treated as exact).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- p  out  2W  product.
- p_mode  out  2  mode the result was computed with.
REQ-003 Clocking SHALL be decided as follows: one clock; reset is asynchronous and active-low.

Function
REQ-004 Partial-product row i (0..W-1) SHALL equal (y AND x[i] replicated) shifted left by i, in 2W bits; M = 2^APPROX_COLS - 1.
REQ-005 Rows SHALL be paired as a=row 2k, b=row 2k+1 (k = 0..W/2-1).
REQ-006 Mode 0/3: each pair SHALL compress to a+b, so p = x*y exactly.
REQ-007 Mode 1: each pair SHALL compress to ((a OR b) AND M) + ((a AND NOT M) + (b AND NOT M)); low-column carries are dropped.
REQ-008 Mode 2: every row SHALL be ANDed with NOT M before pairing; pairs then add exactly.
REQ-009 p SHALL be the exact 2W-bit sum of all W/2 compressed pairs, computed modulo 2^2W (no overflow possible).
REQ-010 The pipeline SHALL have 3 register stages: S1 operands+mode, S2 compressed pair sums, S3 final sum; latency 3 cycles from accept to out_valid with no backpressure.
REQ-011 An operand SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; a result SHALL leave on a rising edge with out_valid=1 and out_ready=1.
REQ-012 in_ready SHALL equal NOT(out_valid AND NOT out_ready); when in_ready=0, all stages and their valid bits SHALL hold.
REQ-013 When not stalled, each stage valid bit SHALL advance one stage per cycle; bubbles (in_valid=0) propagate as invalid stages.
REQ-014 Throughput SHALL be one result per cycle with out_ready held high.
REQ-015 p and p_mode SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 mode SHALL be sampled per transaction at acceptance; mode changes never affect in-flight operands.
REQ-017 APPROX_COLS=0 SHALL make modes 1 and 2 identical to exact.
REQ-018 Transactions SHALL never be dropped or duplicated; order is preserved.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid=0, p=0, p_mode=0; in_ready=1 during and after reset.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight transactions; first accept after release yields out_valid 3 cycles later.

Verification (W=8, APPROX_COLS=4)
REQ-021 Mode 0, x=255, y=255, out_ready=1 -> p=65025, p_mode=0, out_valid exactly 3 cycles after accept.
REQ-022 Mode 1, x=3, y=3 -> p=7; mode 2, x=3, y=3 -> p=0; mode 1 and 2, x=16, y=16 -> p=256.
REQ-023 Back-to-back modes 0,1,2,3 with x=y=3 -> p sequence 9,7,0,9 on consecutive cycles, p_mode 0,1,2,3.
REQ-024 out_ready=0 for 5 cycles with 4 transactions offered -> in_ready drops once out_valid=1, p held, 3 in flight retained; release -> all 4 delivered in order, none lost.
REQ-025 rst_n pulsed low with 2 transactions in flight -> out_valid=0 and p=0 immediately; no stale result emitted after release.
REQ-026 Random regression, all modes, random in_valid/out_ready -> p matches REQ-004..REQ-009 reference model for every transaction.

Source files
------------

// File: rtl/unsigned_mul_approx_pipe.sv
// -----------------------------------------------------------------------------
// unsigned_mul_approx_pipe
//
// Three-stage pipelined unsigned W x W multiplier with optional approximation
// of the low APPROX_COLS product columns.
//   S1: registered operands and mode
//   S2: registered compressed partial-product pair sums
//   S3: registered final product (p / p_mode / out_valid)
//
// Modes (per transaction, sampled at acceptance):
//   0 / 3 : exact product
//   1     : within each row pair, the low columns are OR-combined
//           (carries out of the low columns are dropped)
//   2     : low columns of every partial-product row are truncated to zero
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transfer request
//   in_ready   block accepts operands this cycle
//   x, y       W-bit unsigned operands
//   mode       2-bit approximation mode
//   out_valid  result available
//   out_ready  downstream accepts result
//   p          2W-bit product
//   p_mode     mode the product was computed with
//
// Flow control: one global stall. When the output holds an unaccepted result,
// every stage freezes and in_ready drops.
// -----------------------------------------------------------------------------
module unsigned_mul_approx_pipe #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic [1:0]       p_mode
);

  localparam int PW = 2 * W;   // product width
  localparam int NP = W / 2;   // number of row pairs

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_OR    = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // Mask of the approximated low columns. Built bit by bit so that
  // APPROX_COLS == 2W never needs a 2^(2W) intermediate.
  function automatic logic [PW-1:0] low_mask();
    logic [PW-1:0] m;
    m = '0;
    for (int j = 0; j < PW; j++) begin
      if (j < APPROX_COLS) m[j] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [PW-1:0] M = low_mask();

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic advance;

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  logic           s1_valid;
  logic [W-1:0]   s1_x;
  logic [W-1:0]   s1_y;
  mode_e          s1_mode;

  logic           s2_valid;
  logic [PW-1:0]  s2_pair [NP];
  mode_e          s2_mode;

  // ---------------------------------------------------------------------------
  // S1 -> S2: partial-product rows and pair compression
  // ---------------------------------------------------------------------------
  logic [PW-1:0] row    [W];
  logic [PW-1:0] pair_d [NP];

  always_comb begin
    for (int i = 0; i < W; i++) begin
      row[i] = s1_x[i] ? (PW'(s1_y) << i) : '0;
      // Truncation clears the low columns before any addition happens.
      if (s1_mode == MODE_TRUNC) row[i] = row[i] & ~M;
    end
  end

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      pair_d[k] = '0;
      case (s1_mode)
        // Low columns: OR instead of add, so no carry leaves the low field.
        MODE_OR: pair_d[k] = ((row[2*k] | row[2*k+1]) & M)
                           + ((row[2*k] & ~M) + (row[2*k+1] & ~M));
        // Exact, reserved, and truncate (rows already masked) add exactly.
        default: pair_d[k] = row[2*k] + row[2*k+1];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // S2 -> S3: final sum of pair results, modulo 2^(2W)
  // ---------------------------------------------------------------------------
  logic [PW-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NP; k++) begin
      sum_d = sum_d + s2_pair[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Control and output registers (reset)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its source, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
      p_mode    <= 2'd0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        p      <= sum_d;
        p_mode <= s2_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: pipeline data registers are left unreset on purpose; their contents
  // are only ever observed behind a valid bit that reset does clear.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_x    <= x;
      s1_y    <= y;
      s1_mode <= mode_e'(mode);
    end
    if (advance && s1_valid) begin
      for (int k = 0; k < NP; k++) begin
        s2_pair[k] <= pair_d[k];
      end
      s2_mode <= s1_mode;
    end
  end

endmodule

// File: tb/tb_unsigned_mul_approx_pipe.sv
// -----------------------------------------------------------------------------
// tb_unsigned_mul_approx_pipe
//
// Self-checking bench for unsigned_mul_approx_pipe (W=8, APPROX_COLS=4).
// Inputs are driven 1 time unit after a rising edge; outputs and handshakes
// are sampled on the falling edge, when everything is stable for the next
// rising edge.
// -----------------------------------------------------------------------------
module tb_unsigned_mul_approx_pipe;

  localparam int W  = 8;
  localparam int AC = 4;
  localparam int PW = 2 * W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x         = '0;
  logic [W-1:0]  y         = '0;
  logic [1:0]    mode      = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] p;
  logic [1:0]    p_mode;

  int n_checks = 0;
  int n_errors = 0;

  unsigned_mul_approx_pipe #(
    .W           (W),
    .APPROX_COLS (AC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .p_mode    (p_mode)
  );

  always #5 clk = ~clk;

  // Reference model: sum over row pairs, each pair combined per mode.
  function automatic logic [PW-1:0] ref_mul(input int unsigned xv, input int unsigned yv,
                                            input int md);
    longint unsigned acc;
    longint unsigned m;
    longint unsigned a;
    longint unsigned b;
    longint unsigned s;
    acc = 0;
    m   = (64'd1 << AC) - 1;
    for (int k = 0; k < W / 2; k++) begin
      a = ((xv >> (2 * k)) & 1) != 0 ? longint'(yv) << (2 * k) : 0;
      b = ((xv >> (2 * k + 1)) & 1) != 0 ? longint'(yv) << (2 * k + 1) : 0;
      case (md)
        1:       s = ((a | b) & m) + ((a & ~m) + (b & ~m));
        2:       s = (a & ~m) + (b & ~m);
        default: s = a + b;
      endcase
      acc = acc + s;
    end
    acc = acc % (64'd1 << PW);
    return acc[PW-1:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high. lat counts rising edges from the
  // accepting edge (inclusive) until out_valid is seen; -1 on timeout.
  task automatic send_and_get(input logic [W-1:0] xv, input logic [W-1:0] yv,
                              input logic [1:0] mv, output logic [PW-1:0] pv,
                              output logic [1:0] mdv, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x         = xv;
    y         = yv;
    mode      = mv;
    next_cycle();
    in_valid = 1'b0;
    lat      = 1;
    pv       = '0;
    mdv      = 2'd0;
    while (1) begin
      @(negedge clk);
      if (out_valid) begin
        pv  = p;
        mdv = p_mode;
        break;
      end
      if (lat >= 10) begin
        lat = -1;
        break;
      end
      next_cycle();
      lat++;
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (p !== '0 || p_mode !== 2'd0) begin
      n_errors++; $display("FAIL reset_p: got p=%0d p_mode=%0d expected 0/0", p, p_mode);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    logic [PW-1:0] pv;
    logic [1:0]    mv;
    int            lat;
    send_and_get(8'd255, 8'd255, 2'd0, pv, mv, lat);
    n_checks++;
    if (lat !== 3) begin
      n_errors++; $display("FAIL latency: got %0d cycles expected 3", lat);
    end
    n_checks++;
    if (pv !== 16'd65025 || mv !== 2'd0) begin
      n_errors++; $display("FAIL max_operands: got p=%0d mode=%0d expected 65025/0", pv, mv);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL no_duplicate: got out_valid=%b expected 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_modes();
    logic [W-1:0]  tx   [5] = '{8'd3, 8'd3, 8'd16, 8'd16, 8'd3};
    logic [W-1:0]  ty   [5] = '{8'd3, 8'd3, 8'd16, 8'd16, 8'd3};
    logic [1:0]    tm   [5] = '{2'd1, 2'd2, 2'd1,  2'd2,  2'd0};
    logic [PW-1:0] texp [5] = '{16'd7, 16'd0, 16'd256, 16'd256, 16'd9};
    logic [PW-1:0] pv;
    logic [1:0]    mv;
    int            lat;
    for (int i = 0; i < 5; i++) begin
      send_and_get(tx[i], ty[i], tm[i], pv, mv, lat);
      n_checks++;
      if (lat !== 3 || pv !== texp[i] || mv !== tm[i]) begin
        n_errors++;
        $display("FAIL mode_case_%0d: got p=%0d mode=%0d lat=%0d expected p=%0d mode=%0d lat=3",
                 i, pv, mv, lat, texp[i], tm[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] bexp [4] = '{16'd9, 16'd7, 16'd0, 16'd9};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        in_valid = 1'b1; x = 8'd3; y = 8'd3; mode = 2'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (i >= 3 && i <= 6) begin
        if (out_valid !== 1'b1 || p !== bexp[i-3] || p_mode !== 2'(i - 3)) begin
          n_errors++;
          $display("FAIL back_to_back_%0d: got v=%b p=%0d mode=%0d expected v=1 p=%0d mode=%0d",
                   i - 3, out_valid, p, p_mode, bexp[i-3], i - 3);
        end
      end else if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL back_to_back_idle_%0d: got out_valid=%b expected 0", i, out_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  bx   [4];
    logic [W-1:0]  by   [4];
    logic [PW-1:0] bexp [4];
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      bx[i]   = 8'(20 + 37 * i);
      by[i]   = 8'(3 + 50 * i);
      bexp[i] = ref_mul(bx[i], by[i], i);
    end
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        x = bx[idx]; y = by[idx]; mode = 2'(idx);
      end
      @(negedge clk);
      if (c == 3 || c == 4) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_errors++; $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b1 || p !== bexp[0]) begin
          n_errors++;
          $display("FAIL stall_hold_c%0d: got v=%b p=%0d expected v=1 p=%0d", c, out_valid, p, bexp[0]);
        end
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        n_checks++;
        if (p !== bexp[got] || p_mode !== 2'(got)) begin
          n_errors++;
          $display("FAIL stall_order_%0d: got p=%0d mode=%0d expected p=%0d mode=%0d",
                   got, p, p_mode, bexp[got], got);
        end
        got++;
      end
      next_cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (got !== 4) begin
      n_errors++; $display("FAIL stall_delivered: got %0d results expected 4", got);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++; $display("FAIL stall_extra: got out_valid=%b expected 0", out_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] pv;
    logic [1:0]    mv;
    int            lat;
    out_ready = 1'b1;
    in_valid  = 1'b1; x = 8'd7;  y = 8'd9;  mode = 2'd0;
    next_cycle();
    x = 8'd11; y = 8'd13;
    next_cycle();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || p !== '0 || p_mode !== 2'd0) begin
      n_errors++;
      $display("FAIL midreset_clear: got v=%b p=%0d mode=%0d expected 0/0/0", out_valid, p, p_mode);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++; $display("FAIL midreset_stale_%0d: got out_valid=%b expected 0", i, out_valid);
      end
      next_cycle();
    end
    send_and_get(8'd5, 8'd6, 2'd0, pv, mv, lat);
    n_checks++;
    if (lat !== 3 || pv !== 16'd30) begin
      n_errors++; $display("FAIL midreset_first: got p=%0d lat=%0d expected p=30 lat=3", pv, lat);
    end
  endtask

  task automatic test_random();
    logic [PW+1:0] sbq [$];
    logic [PW+1:0] e;
    logic          held_valid = 1'b0;
    logic [PW-1:0] held_p     = '0;
    logic [1:0]    held_m     = 2'd0;
    int            n_acc      = 0;
    int            n_out      = 0;
    for (int c = 0; c < 900; c++) begin
      if (c < 700) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        x         = 8'($urandom);
        y         = 8'($urandom);
        mode      = 2'($urandom);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_errors++;
        $display("FAIL rand_in_ready_c%0d: got %b with out_valid=%b out_ready=%b",
                 c, in_ready, out_valid, out_ready);
      end
      if (held_valid) begin
        n_checks++;
        if (out_valid !== 1'b1 || p !== held_p || p_mode !== held_m) begin
          n_errors++;
          $display("FAIL rand_hold_c%0d: got v=%b p=%0d mode=%0d expected v=1 p=%0d mode=%0d",
                   c, out_valid, p, p_mode, held_p, held_m);
        end
      end
      if (in_valid && in_ready) begin
        sbq.push_back({mode, ref_mul(x, y, int'(mode))});
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_errors++; $display("FAIL rand_extra_c%0d: got unexpected p=%0d expected none", c, p);
        end else begin
          e = sbq.pop_front();
          if ({p_mode, p} !== e) begin
            n_errors++;
            $display("FAIL rand_result_%0d: got p=%0d mode=%0d expected p=%0d mode=%0d",
                     n_out, p, p_mode, e[PW-1:0], e[PW+1:PW]);
          end
        end
        n_out++;
      end
      held_valid = out_valid && !out_ready;
      held_p     = p;
      held_m     = p_mode;
      next_cycle();
    end
    n_checks++;
    if (sbq.size() != 0 || n_out != n_acc) begin
      n_errors++;
      $display("FAIL rand_drain: got %0d results for %0d accepted, %0d pending expected 0",
               n_out, n_acc, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
